// File: rtl/osc_monitor_if.sv
// Oscillator monitor bus: the control inputs and measurement results
// exchanged between the monitor and the block that owns it.
interface osc_monitor_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             osc_in;
  logic             clear_fault;
  logic             osc_en;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             in_range;
  logic             fault;

  // Owner side: requests measurement, supplies the oscillator, reads results.
  modport master (
    output enable, osc_in, clear_fault,
    input  osc_en, count, count_valid, in_range, fault
  );

  // Monitor side.
  modport slave (
    input  enable, osc_in, clear_fault,
    output osc_en, count, count_valid, in_range, fault
  );
endinterface

// File: rtl/osc_monitor.sv
// Oscillator monitor: enables an on-chip oscillator, waits for it to settle,
// counts its rising edges over a fixed window of clk cycles and flags any
// window whose count falls outside [MIN_CNT, MAX_CNT] with a sticky fault.
module osc_monitor #(
  parameter int WINDOW  = 27000,
  parameter int SETTLE  = 1024,
  parameter int CNT_W   = 16,
  parameter int MIN_CNT = 0,
  parameter int MAX_CNT = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  osc_monitor_if.slave bus
);

  // One shared tick counter times both the settle period and the window.
  localparam int LONGEST = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TICK_W  = (LONGEST > 1) ? $clog2(LONGEST) : 1;
  localparam logic [TICK_W-1:0] SETTLE_LAST = TICK_W'(SETTLE - 1);
  localparam logic [TICK_W-1:0] WINDOW_LAST = TICK_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT
  } state_t;

  state_t            r_state;
  logic [TICK_W-1:0] r_tick;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_hist;
  logic              r_osc_en;
  logic [CNT_W-1:0]  r_count;
  logic              r_count_valid;
  logic              r_in_range;
  logic              r_fault;

  logic              w_rise;
  int                w_cnt_val;
  logic              w_in_range;

  // Rising edge of the synchronised oscillator, one clk wide.
  assign w_rise = r_sync2 & ~r_hist;

  // Range test done in signed int so a MIN_CNT of 0 is not a constant compare.
  assign w_cnt_val  = int'(r_edge_cnt);
  assign w_in_range = (w_cnt_val >= MIN_CNT) && (w_cnt_val <= MAX_CNT);

  assign bus.osc_en      = r_osc_en;
  assign bus.count       = r_count;
  assign bus.count_valid = r_count_valid;
  assign bus.in_range    = r_in_range;
  assign bus.fault       = r_fault;

  // Two-flop synchroniser for the asynchronous oscillator plus a history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      // NOTE: non-blocking, so each flop takes its neighbour's pre-edge value
      // and the chain really is three stages deep.
      r_sync1 <= bus.osc_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  // Control FSM with registered outputs: settle, measure, report, repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_tick        <= '0;
      r_edge_cnt    <= '0;
      r_osc_en      <= 1'b0;
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_in_range    <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      // A fault raised in REPORT below overrides this clear.
      if (bus.clear_fault) r_fault <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          r_tick     <= '0;
          r_edge_cnt <= '0;
          if (bus.enable) begin
            r_state  <= ST_SETTLE;
            r_osc_en <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (!bus.enable) begin
            r_state  <= ST_IDLE;
            r_osc_en <= 1'b0;
            r_tick   <= '0;
          end else if (r_tick == SETTLE_LAST) begin
            r_state    <= ST_MEASURE;
            r_tick     <= '0;
            r_edge_cnt <= '0;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        ST_MEASURE: begin
          if (!bus.enable) begin
            // Abandon the partial window; published results stay untouched.
            r_state    <= ST_IDLE;
            r_osc_en   <= 1'b0;
            r_tick     <= '0;
            r_edge_cnt <= '0;
          end else begin
            if (w_rise && (r_edge_cnt != '1)) r_edge_cnt <= r_edge_cnt + 1'b1;
            if (r_tick == WINDOW_LAST) begin
              r_state <= ST_REPORT;
              r_tick  <= '0;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
        end

        ST_REPORT: begin
          r_count       <= r_edge_cnt;
          r_count_valid <= 1'b1;
          r_in_range    <= w_in_range;
          if (!w_in_range) r_fault <= 1'b1;
          r_edge_cnt    <= '0;
          r_tick        <= '0;
          // The oscillator is already settled, so a new window starts at once.
          if (bus.enable) begin
            r_state <= ST_MEASURE;
          end else begin
            r_state  <= ST_IDLE;
            r_osc_en <= 1'b0;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_osc_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
